// File: rtl/dram_cmd_arbiter.sv
// rtl/dram_cmd_arbiter.sv - per-rank DRAM command arbiter with PREA/REF refresh sequencing
// Optional ARB_AGE_PRIORITY_EN: per-bank age counters let a starved bank override class priority.
module dram_cmd_arbiter #(
   parameter int NUM_BANKS  = 8,
   parameter int BA_BITS    = 3,
   parameter int CYCLE_TRRD = 4,
   parameter int CYCLE_TCCD = 4,
   parameter int CYCLE_TRP  = 11,
   parameter int CYCLE_TRFC = 88
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BANKS-1:0]   bank_req_valid,
   input  logic [2*NUM_BANKS-1:0] bank_req_cmd,
   input  logic [NUM_BANKS-1:0]   bank_timer_zero,
   input  logic [NUM_BANKS-1:0]   bank_tras_ok,
   output logic [NUM_BANKS-1:0]   bank_grant,
   output logic                   cmd_valid,
   output logic [2:0]             cmd_type,
   output logic [BA_BITS-1:0]     cmd_bank,
   input  logic                   ref_req,
   output logic                   ref_ack,
   output logic                   ref_busy
);
   localparam logic [1:0] S_NORMAL = 2'd0;
   localparam logic [1:0] S_DRAIN  = 2'd1;
   localparam logic [1:0] S_TRP    = 2'd2;
   localparam logic [1:0] S_TRFC   = 2'd3;

   localparam logic [1:0] REQ_ACT   = 2'd0;
   localparam logic [1:0] REQ_READ  = 2'd1;
   localparam logic [1:0] REQ_WRITE = 2'd2;

   localparam logic [2:0] CMD_NOP  = 3'd0;
   localparam logic [2:0] CMD_PREA = 3'd5;
   localparam logic [2:0] CMD_REF  = 3'd6;

   localparam logic [7:0] TRRD_LOAD = 8'(CYCLE_TRRD - 1);
   localparam logic [7:0] TCCD_LOAD = 8'(CYCLE_TCCD - 1);
   localparam logic [7:0] TRP_LOAD  = 8'(CYCLE_TRP - 1);
   localparam logic [7:0] TRFC_LOAD = 8'(CYCLE_TRFC - 1);

   logic [1:0]           state, state_nxt;
   logic [7:0]           trrd_cnt, tccd_cnt, wait_cnt;
   logic [BA_BITS-1:0]   rr_ptr;
   logic [NUM_BANKS-1:0] act_elig, rw_elig, pre_elig;
   logic [BA_BITS:0]     rw_pick, act_pick, pre_pick;
   logic                 win_found;
   logic [BA_BITS-1:0]   win_idx;
   logic [1:0]           win_cmd;
   logic                 arb_open;
   logic                 ref_ready;

   // Returns {found, bank}: first set bit searching upward from ptr+1, wrapping.
   function automatic logic [BA_BITS:0] rr_pick(input logic [NUM_BANKS-1:0] elig,
                                                input logic [BA_BITS-1:0]   ptr);
      logic               found;
      logic [BA_BITS-1:0] sel;
      logic [BA_BITS-1:0] idx;
      found = 1'b0;
      sel   = '0;
      for (int i = 1; i <= NUM_BANKS; i++) begin
         idx = ptr + BA_BITS'(i);
         if (!found && elig[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      return {found, sel};
   endfunction

   // A pending refresh request closes arbitration in the same cycle it is seen.
   assign arb_open  = (state == S_NORMAL) && !ref_req;
   assign ref_ready = (&bank_timer_zero) && (&bank_tras_ok);

   always_comb begin
      act_elig = '0;
      rw_elig  = '0;
      pre_elig = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (arb_open && bank_req_valid[b] && !bank_grant[b] && bank_timer_zero[b]) begin
            case (bank_req_cmd[2*b +: 2])
               REQ_ACT:             act_elig[b] = (trrd_cnt == 8'd0);
               REQ_READ, REQ_WRITE: rw_elig[b]  = (tccd_cnt == 8'd0);
               default:             pre_elig[b] = bank_tras_ok[b];
            endcase
         end
      end
   end

`ifdef ARB_AGE_PRIORITY_EN
   logic [NUM_BANKS-1:0] any_elig;
   logic [3:0]           age [NUM_BANKS];
   logic                 old_found;
   logic [BA_BITS-1:0]   old_idx;

   assign any_elig = act_elig | rw_elig | pre_elig;

   always_comb begin
      old_found = 1'b0;
      old_idx   = '0;
      for (int b = NUM_BANKS - 1; b >= 0; b--) begin
         if (any_elig[b] && (age[b] == 4'd15)) begin
            old_found = 1'b1;
            old_idx   = BA_BITS'(b);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BANKS; b++) age[b] <= 4'd0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (!bank_req_valid[b] || (win_found && (win_idx == BA_BITS'(b))))
               age[b] <= 4'd0;
            else if (any_elig[b] && (age[b] != 4'd15))
               age[b] <= age[b] + 4'd1;
         end
      end
   end
`endif

   always_comb begin
      rw_pick   = rr_pick(rw_elig, rr_ptr);
      act_pick  = rr_pick(act_elig, rr_ptr);
      pre_pick  = rr_pick(pre_elig, rr_ptr);
      win_found = 1'b1;
      if (rw_pick[BA_BITS])
         win_idx = rw_pick[BA_BITS-1:0];
      else if (act_pick[BA_BITS])
         win_idx = act_pick[BA_BITS-1:0];
      else if (pre_pick[BA_BITS])
         win_idx = pre_pick[BA_BITS-1:0];
      else begin
         win_found = 1'b0;
         win_idx   = '0;
      end
`ifdef ARB_AGE_PRIORITY_EN
      if (old_found) begin
         win_found = 1'b1;
         win_idx   = old_idx;
      end
`endif
   end

   assign win_cmd = bank_req_cmd[2*win_idx +: 2];

   always_comb begin
      state_nxt = state;
      case (state)
         S_NORMAL: if (ref_req)              state_nxt = S_DRAIN;
         S_DRAIN:  if (ref_ready)            state_nxt = S_TRP;
         S_TRP:    if (wait_cnt == 8'd0)     state_nxt = S_TRFC;
         default:  if (wait_cnt == 8'd0)     state_nxt = S_NORMAL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_NORMAL;
         trrd_cnt   <= 8'd0;
         tccd_cnt   <= 8'd0;
         wait_cnt   <= 8'd0;
         rr_ptr     <= BA_BITS'(NUM_BANKS - 1);
         bank_grant <= '0;
         cmd_valid  <= 1'b0;
         cmd_type   <= CMD_NOP;
         cmd_bank   <= '0;
         ref_ack    <= 1'b0;
         ref_busy   <= 1'b0;
      end else begin
         state      <= state_nxt;
         ref_busy   <= (state_nxt != S_NORMAL);
         bank_grant <= '0;
         cmd_valid  <= 1'b0;
         cmd_type   <= CMD_NOP;
         cmd_bank   <= '0;
         ref_ack    <= 1'b0;
         // Rank windows keep running through refresh.
         trrd_cnt   <= (trrd_cnt != 8'd0) ? trrd_cnt - 8'd1 : 8'd0;
         tccd_cnt   <= (tccd_cnt != 8'd0) ? tccd_cnt - 8'd1 : 8'd0;
         case (state)
            S_NORMAL: begin
               if (win_found) begin
                  bank_grant <= NUM_BANKS'(1) << win_idx;
                  cmd_valid  <= 1'b1;
                  cmd_type   <= {1'b0, win_cmd} + 3'd1;
                  cmd_bank   <= win_idx;
                  rr_ptr     <= win_idx;
                  if (win_cmd == REQ_ACT)
                     trrd_cnt <= TRRD_LOAD;
                  else if ((win_cmd == REQ_READ) || (win_cmd == REQ_WRITE))
                     tccd_cnt <= TCCD_LOAD;
               end
            end
            S_DRAIN: begin
               if (ref_ready) begin
                  cmd_valid <= 1'b1;
                  cmd_type  <= CMD_PREA;
                  wait_cnt  <= TRP_LOAD;
               end
            end
            S_TRP: begin
               if (wait_cnt == 8'd0) begin
                  cmd_valid <= 1'b1;
                  cmd_type  <= CMD_REF;
                  wait_cnt  <= TRFC_LOAD;
               end else begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end
            default: begin
               if (wait_cnt == 8'd0)
                  ref_ack <= 1'b1;
               else
                  wait_cnt <= wait_cnt - 8'd1;
            end
         endcase
      end
   end
endmodule
